wsacc_weight_loader: RTL and testbench



---
 rtl/wsacc_pkg.sv | 13 +
 rtl/wsacc_weight_loader_if.sv | 23 ++
 rtl/wsacc_weight_loader.sv | 145 ++++++++++++++
 tb/tb_wsacc_weight_loader.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/wsacc_pkg.sv
// Shared types and constants for the weight-stationary accelerator blocks.
// Holds the weight-loader state enum plus the address and checksum widths.
package wsacc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } wload_state_t;

    localparam int WSACC_ADDR_W = 4;
    localparam int WSACC_CSUM_W = 16;

endpackage

// File: rtl/wsacc_weight_loader_if.sv
// Valid/ready weight stream feeding the weight loader.
// The master (buffer/DMA side) drives valid and data; the loader answers with ready.
interface wsacc_weight_loader_if #(
    parameter int dataWidth = 8
);

    logic                 w_valid_i;
    logic                 w_ready_o;
    logic [dataWidth-1:0] w_data_i;

    modport master (
        output w_valid_i,
        output w_data_i,
        input  w_ready_o
    );

    modport slave (
        input  w_valid_i,
        input  w_data_i,
        output w_ready_o
    );

endinterface

// File: rtl/wsacc_weight_loader.sv
// Weight-load sequencer: fills numPe PEs with windowElements weights each from a stream.
// Optional running checksum of accepted weights is enabled by defining WSACC_WLOAD_CHECKSUM_EN.
module wsacc_weight_loader
    import wsacc_pkg::*;
#(
    parameter int dataWidth      = 8,
    parameter int windowElements = 9,
    parameter int numPe          = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    abort_i,
    output logic                    busy_o,
    output logic                    done_o,
    wsacc_weight_loader_if.slave    w_if,
    output logic [numPe-1:0]        weight_wr_en_o,
    output logic [WSACC_ADDR_W-1:0] weight_addr_o,
    output logic [dataWidth-1:0]    weight_o
`ifdef WSACC_WLOAD_CHECKSUM_EN
    ,
    output logic [WSACC_CSUM_W-1:0] checksum_o
`endif
);

    localparam int PE_W = (numPe > 1) ? $clog2(numPe) : 1;
    localparam logic [WSACC_ADDR_W-1:0] LAST_ELEM = WSACC_ADDR_W'(windowElements - 1);
    localparam logic [PE_W-1:0]         LAST_PE   = PE_W'(numPe - 1);

    if (windowElements < 1 || windowElements > 16) begin : g_bad_window
        $error("wsacc_weight_loader: windowElements must be in 1..16");
    end
    if (numPe < 1) begin : g_bad_num_pe
        $error("wsacc_weight_loader: numPe must be at least 1");
    end

    wload_state_t             state_q, state_d;
    logic [PE_W-1:0]          pe_idx_q, pe_idx_d;
    logic [WSACC_ADDR_W-1:0]  elem_q, elem_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [numPe-1:0]         wr_en_q, wr_en_d;
    logic [WSACC_ADDR_W-1:0]  waddr_q, waddr_d;
    logic [dataWidth-1:0]     weight_q, weight_d;
`ifdef WSACC_WLOAD_CHECKSUM_EN
    logic [WSACC_CSUM_W-1:0]  csum_q, csum_d;
`endif

    logic handshake;

    // Abort blocks acceptance combinationally so a word offered alongside it is never taken.
    assign w_if.w_ready_o = (state_q == LOAD) && !abort_i;
    assign handshake      = w_if.w_valid_i && w_if.w_ready_o;

    always_comb begin
        state_d  = state_q;
        pe_idx_d = pe_idx_q;
        elem_d   = elem_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        wr_en_d  = '0;
        waddr_d  = waddr_q;
        weight_d = weight_q;
`ifdef WSACC_WLOAD_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = LOAD;
                    pe_idx_d = '0;
                    elem_d   = '0;
                    busy_d   = 1'b1;
`ifdef WSACC_WLOAD_CHECKSUM_EN
                    csum_d   = '0;
`endif
                end
            end
            LOAD: begin
                if (abort_i) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (handshake) begin
                    wr_en_d  = numPe'(1) << pe_idx_q;
                    waddr_d  = elem_q;
                    weight_d = w_if.w_data_i;
`ifdef WSACC_WLOAD_CHECKSUM_EN
                    csum_d   = csum_q + WSACC_CSUM_W'(signed'(w_if.w_data_i));
`endif
                    if (elem_q == LAST_ELEM) begin
                        elem_d = '0;
                        if (pe_idx_q == LAST_PE) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            pe_idx_d = pe_idx_q + PE_W'(1);
                        end
                    end else begin
                        elem_d = elem_q + WSACC_ADDR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pe_idx_q <= '0;
            elem_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_en_q  <= '0;
            waddr_q  <= '0;
            weight_q <= '0;
`ifdef WSACC_WLOAD_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            pe_idx_q <= pe_idx_d;
            elem_q   <= elem_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wr_en_q  <= wr_en_d;
            waddr_q  <= waddr_d;
            weight_q <= weight_d;
`ifdef WSACC_WLOAD_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign weight_wr_en_o = wr_en_q;
    assign weight_addr_o  = waddr_q;
    assign weight_o       = weight_q;
`ifdef WSACC_WLOAD_CHECKSUM_EN
    assign checksum_o     = csum_q;
`endif

endmodule

// File: tb/tb_wsacc_weight_loader.sv
// Randomised scoreboard bench for wsacc_weight_loader (4 PEs x 9 weights).
// Checksum checks are included when WSACC_WLOAD_CHECKSUM_EN is defined.
module tb_wsacc_weight_loader;

    localparam int DW    = 8;
    localparam int WE    = 9;
    localparam int NPE   = 4;
    localparam int TOTAL = NPE * WE;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start_i = 1'b0;
    logic           abort_i = 1'b0;
    logic           busy_o;
    logic           done_o;
    logic [NPE-1:0] weight_wr_en_o;
    logic [3:0]     weight_addr_o;
    logic [DW-1:0]  weight_o;
`ifdef WSACC_WLOAD_CHECKSUM_EN
    logic [15:0]    checksum_o;
`endif

    wsacc_weight_loader_if #(.dataWidth(DW)) w_if ();

    always #5 clk = ~clk;

    wsacc_weight_loader #(
        .dataWidth      (DW),
        .windowElements (WE),
        .numPe          (NPE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .w_if           (w_if.slave),
        .weight_wr_en_o (weight_wr_en_o),
        .weight_addr_o  (weight_addr_o),
        .weight_o       (weight_o)
`ifdef WSACC_WLOAD_CHECKSUM_EN
        ,
        .checksum_o     (checksum_o)
`endif
    );

    typedef struct packed {
        logic [NPE-1:0] en;
        logic [3:0]     addr;
        logic [DW-1:0]  data;
        logic           done;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    int          checks = 0;
    int          errors = 0;

    // Reference model: whether a load is active, words accepted so far, running checksum.
    bit          m_load  = 1'b0;
    int          m_count = 0;
    logic [15:0] m_csum  = 16'h0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset();
        check_output("rst_busy",   32'(busy_o), 32'd0);
        check_output("rst_done",   32'(done_o), 32'd0);
        check_output("rst_ready",  32'(w_if.w_ready_o), 32'd0);
        check_output("rst_wr_en",  32'(weight_wr_en_o), 32'd0);
        check_output("rst_addr",   32'(weight_addr_o), 32'd0);
        check_output("rst_weight", 32'(weight_o), 32'd0);
`ifdef WSACC_WLOAD_CHECKSUM_EN
        check_output("rst_csum",   32'(checksum_o), 32'd0);
`endif
    endtask

    // One clock of stimulus; the model decides from its own rules what the DUT must do.
    task automatic apply_stimulus(input bit st, input bit ab, input bit vl,
                                  input logic [DW-1:0] d, input bit rs);
        wr_t e;
        @(negedge clk);
        check_output("busy", 32'(busy_o), 32'(m_load));
`ifdef WSACC_WLOAD_CHECKSUM_EN
        check_output("checksum", 32'(checksum_o), 32'(m_csum));
`endif
        start_i        = st;
        abort_i        = ab;
        w_if.w_valid_i = vl;
        w_if.w_data_i  = d;
        rst            = rs;
        #1;
        check_output("w_ready", 32'(w_if.w_ready_o), 32'(m_load && !ab));
        if (rs) begin
            m_load  = 1'b0;
            m_count = 0;
            m_csum  = 16'h0;
        end else if (!m_load) begin
            if (st) begin
                m_load  = 1'b1;
                m_count = 0;
                m_csum  = 16'h0;
            end
        end else if (ab) begin
            m_load = 1'b0;
        end else if (vl) begin
            e.en   = NPE'(1) << (m_count / WE);
            e.addr = 4'(m_count % WE);
            e.data = d;
            e.done = (m_count == TOTAL - 1);
            exp_q.push_back(e);
            m_csum  = m_csum + {{(16-DW){d[DW-1]}}, d};
            m_count = m_count + 1;
            if (m_count == TOTAL) m_load = 1'b0;
        end
    endtask

    // mode 0: sequential data 1..36, 1: alternating valid, 2: random valid/data, 3: all 0xFF
    task automatic run_load(input int mode, input bit mid_start);
        bit            vl;
        logic [DW-1:0] d;
        apply_stimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        for (int cyc = 0; cyc < 400 && m_load; cyc++) begin
            case (mode)
                0:       begin vl = 1'b1; d = DW'(m_count + 1); end
                1:       begin vl = (cyc % 2 == 0); d = DW'($urandom); end
                2:       begin vl = 1'($urandom_range(0, 1)); d = DW'($urandom); end
                default: begin vl = 1'b1; d = 8'hFF; end
            endcase
            apply_stimulus(mid_start && (cyc % 7 == 3), 1'b0, vl, d, 1'b0);
        end
    endtask

    // Monitor: every write-enable or done pulse must match the next expected write.
    always @(posedge clk) begin
        #1;
        if (weight_wr_en_o !== '0 || done_o !== 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: got en 0x%0h done %0b expected none at %0t",
                         weight_wr_en_o, done_o, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check_output("wr_en",  32'(weight_wr_en_o), 32'(mon_e.en));
                check_output("addr",   32'(weight_addr_o),  32'(mon_e.addr));
                check_output("weight", 32'(weight_o),       32'(mon_e.data));
                check_output("done",   32'(done_o),         32'(mon_e.done));
            end
        end
    end

    initial begin
        w_if.w_valid_i = 1'b0;
        w_if.w_data_i  = '0;
        repeat (2) @(posedge clk);
        #2;
        check_reset();

        run_load(0, 1'b0);
        run_load(1, 1'b0);
        repeat (3) apply_stimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);

        apply_stimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 1'b0, 1'b1, DW'($urandom), 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b1, DW'($urandom), 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b1, DW'($urandom), 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b1, DW'($urandom), 1'b0);
        run_load(2, 1'b1);

        apply_stimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b0, 1'b1, DW'($urandom), 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b1, DW'($urandom), 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b1, DW'($urandom), 1'b1);
        @(posedge clk);
        #2;
        check_reset();

        run_load(3, 1'b0);
`ifdef WSACC_WLOAD_CHECKSUM_EN
        @(posedge clk);
        #2;
        check_output("csum_all_ff", 32'(checksum_o), 32'h0000FFDC);
`endif
        run_load(0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            apply_stimulus(($urandom % 8) == 0, ($urandom % 20) == 0, 1'($urandom_range(0, 1)),
                           DW'($urandom), 1'b0);
        end

        repeat (3) apply_stimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        check_output("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
